serial_paralelo_rx: RTL



---
 rtl/serial_paralelo_rx_pkg.sv | 26 ++
 rtl/sp_rx_shifter.sv | 51 +++++
 rtl/serial_paralelo_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_rx_pkg.sv
// ----------------------------------------------------------------------------
// serial_paralelo_rx_pkg
// Shared definitions for the serial-paralelo receive path. The Tx side and
// its bench use the same symbols.
//   COM_SYM_DEF : comma symbol used for alignment and idle fill (0xBC)
//   IDLE_SYM    : idle data symbol (0x7C)
//   sp_rx_state_e : receiver FSM states, 2-bit encoding
//   sat_inc4    : saturating 4-bit increment for the comma counter
// ----------------------------------------------------------------------------
package serial_paralelo_rx_pkg;

    localparam logic [7:0] COM_SYM_DEF = 8'hBC;
    localparam logic [7:0] IDLE_SYM    = 8'h7C;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } sp_rx_state_e;

    // The comma counter must never wrap back to zero.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/sp_rx_shifter.sv
// ----------------------------------------------------------------------------
// sp_rx_shifter
// MSB-first input shift register plus the bit-phase counter of the receiver.
// Ports:
//   clk_1    : bit-rate clock
//   reset    : asynchronous active-high reset
//   data_in  : serial line bit
//   cnt_clr  : synchronous clear of bit_cnt (priority over cnt_en)
//   cnt_en   : advance bit_cnt modulo 8
//   sr_next  : {sr[6:0], data_in}, the byte window including this cycle's bit
//   boundary : bit_cnt == 7, sr_next holds a complete aligned byte
// ----------------------------------------------------------------------------
module sp_rx_shifter (
    input  logic       clk_1,
    input  logic       reset,
    input  logic       data_in,
    input  logic       cnt_clr,
    input  logic       cnt_en,
    output logic [7:0] sr_next,
    output logic       boundary
);

    logic [7:0] sr_reg;
    logic [2:0] bit_cnt_reg;

    // The window is combinational so the FSM can act on the edge that
    // samples the last bit of a byte.
    assign sr_next[0] = data_in;
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_shift
            assign sr_next[gi+1] = sr_reg[gi];
        end
    endgenerate

    assign boundary = (bit_cnt_reg == 3'd7);

    always_ff @(posedge clk_1 or posedge reset) begin
        if (reset) begin
            sr_reg      <= 8'd0;
            bit_cnt_reg <= 3'd0;
        end else begin
            sr_reg <= sr_next;
            if (cnt_clr) begin
                bit_cnt_reg <= 3'd0;
            end else if (cnt_en) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// ----------------------------------------------------------------------------
// serial_paralelo_rx
// Receive-side serial-to-parallel converter. Hunts for the comma symbol at
// any bit phase, locks byte alignment after COM_COUNT consecutive aligned
// commas, then delivers parallel bytes with a valid strobe and an idle level.
// Ports:
//   clk_1     : bit-rate clock, all logic on posedge
//   reset     : asynchronous active-high reset
//   data_in   : serial line bit, MSB first
//   data_out  : last aligned non-comma byte received
//   valid_out : one-cycle pulse when data_out takes a new data byte
//   idle_out  : last aligned byte while ACTIVE was the comma
//   active    : high while the FSM is in ACTIVE
// Optional build macro:
//   SP_RX_RESYNC_EN : a comma seen off the byte boundary while ACTIVE drops
//                     lock and restarts alignment on that comma. Without it
//                     ACTIVE is held until reset.
// ----------------------------------------------------------------------------
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk_1,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       idle_out,
    output logic       active
);

    localparam logic [4:0] COM_COUNT_W = 5'(COM_COUNT);

    // A single comma is enough when COM_COUNT is 1, so the hit goes
    // straight to ACTIVE.
    localparam sp_rx_state_e HIT_STATE = (COM_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;

    sp_rx_state_e state_reg, state_next;
    logic [3:0]   com_cnt_reg, com_cnt_next;
    logic [7:0]   data_next;
    logic         valid_next, idle_next;
    logic         cnt_clr, cnt_en;
    logic [7:0]   sr_next;
    logic         boundary;
    logic         is_com;

    sp_rx_shifter u_shifter (
        .clk_1    (clk_1),
        .reset    (reset),
        .data_in  (data_in),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .sr_next  (sr_next),
        .boundary (boundary)
    );

    // Plain equality: an X anywhere in the window gives no match, so an
    // undriven line never advances the FSM.
    assign is_com = (sr_next == COM_SYM);

    always_comb begin
        state_next   = state_reg;
        com_cnt_next = com_cnt_reg;
        data_next    = data_out;
        valid_next   = 1'b0;
        idle_next    = idle_out;
        cnt_clr      = 1'b0;
        cnt_en       = (state_reg != ST_SEARCH);

        case (state_reg)
            ST_SEARCH: begin
                if (is_com) begin
                    cnt_clr      = 1'b1;
                    com_cnt_next = 4'd1;
                    state_next   = HIT_STATE;
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_next = sat_inc4(com_cnt_reg);
                        if (({1'b0, com_cnt_reg} + 5'd1) == COM_COUNT_W) begin
                            state_next = ST_ACTIVE;
                            idle_next  = 1'b1;
                        end
                    end else begin
                        // Broken run: drop this byte and hunt again from the
                        // next bit, not from this window.
                        state_next   = ST_SEARCH;
                        com_cnt_next = 4'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (boundary) begin
                    if (is_com) begin
                        idle_next = 1'b1;
                    end else begin
                        data_next  = sr_next;
                        valid_next = 1'b1;
                        idle_next  = 1'b0;
                    end
                end
`ifdef SP_RX_RESYNC_EN
                else if (is_com) begin
                    // Misaligned comma: lose lock and reuse this comma as
                    // the first hit of a new alignment run.
                    cnt_clr      = 1'b1;
                    com_cnt_next = 4'd1;
                    state_next   = HIT_STATE;
                    idle_next    = 1'b0;
                end
`endif
            end
            default: begin
                state_next   = ST_SEARCH;
                com_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_1 or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_SEARCH;
            com_cnt_reg <= 4'd0;
            data_out    <= 8'd0;
            valid_out   <= 1'b0;
            idle_out    <= 1'b0;
            active      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            com_cnt_reg <= com_cnt_next;
            data_out    <= data_next;
            valid_out   <= valid_next;
            idle_out    <= idle_next;
            active      <= (state_next == ST_ACTIVE);
        end
    end

endmodule
